// File: rtl/ntt_ctrl_pkg.sv
// Shared types and constants for the NTT stage controller and its core interface.
package ntt_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
    typedef enum logic [1:0] {MODE_0 = 2'd0, MODE_1 = 2'd1, MODE_2 = 2'd2} mode_t;

    localparam int LOG_W  = 4;
    localparam int DATA_W = 30;

    // Twiddle mode is a pure function of the stage index.
    function automatic mode_t mode_of(input logic [LOG_W-1:0] lm, input int m1, input int m2);
        if (int'(lm) < m1) return MODE_0;
        if (int'(lm) < m2) return MODE_1;
        return MODE_2;
    endfunction
endpackage

// File: rtl/ntt_stage_controller_if.sv
// Scheduler/core-side bundle of the NTT stage controller (master = controller).
interface ntt_stage_controller_if
    import ntt_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [LOG_W-1:0]      log_m;
    logic [1:0]            mode;
    logic [ADDR_W:0]       i;
    logic [ADDR_W-1:0]     upper_read_address;
    logic [ADDR_W-1:0]     lower_read_address;
    logic [DATA_W-1:0]     r1, r2, r3, r4;
    logic                  write_enable;
    logic [ADDR_W-1:0]     upper_write_address;
    logic [ADDR_W-1:0]     lower_write_address;
    logic [2*DATA_W-1:0]   upper_data_input;
    logic [2*DATA_W-1:0]   lower_data_input;

    modport master (
        input  start, r1, r2, r3, r4,
        output busy, done, log_m, mode, i, upper_read_address, lower_read_address,
               write_enable, upper_write_address, lower_write_address,
               upper_data_input, lower_data_input
    );
    modport slave (
        output start, r1, r2, r3, r4,
        input  busy, done, log_m, mode, i, upper_read_address, lower_read_address,
               write_enable, upper_write_address, lower_write_address,
               upper_data_input, lower_data_input
    );
endinterface

// File: rtl/ntt_addr_delay_line.sv
// Fixed-latency shift register carrying {valid, address} from read issue to write-back.
module ntt_addr_delay_line #(
    parameter int PIPE_LAT = 8,
    parameter int W        = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [PIPE_LAT-1:0][W-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if (en) begin
            pipe[0] <= d;
            for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign q = pipe[PIPE_LAT-1];
endmodule

// File: rtl/ntt_stage_controller.sv
// Stage sequencer and write-back for one ntt_core.
// Optional NTT_CTRL_STALL_EN adds a stall input that freezes sequencing and the delay line.
module ntt_stage_controller
    import ntt_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int NUM_STAGES  = 12,
    parameter int PIPE_LAT    = 8,
    parameter int MODE1_START = 5,
    parameter int MODE2_START = 9
) (
    input  logic clk,
    input  logic rst_n,
`ifdef NTT_CTRL_STALL_EN
    input  logic stall,
`endif
    ntt_stage_controller_if.master bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(PIPE_LAT + 1);

    state_t            state;
    logic [ADDR_W-1:0] rd_cnt;
    logic [CNT_W-1:0]  drain_cnt;
    logic [LOG_W-1:0]  log_m;
    logic              hold;
    logic              rd_valid;
    mode_t             cur_mode;
    logic [ADDR_W:0]   i_shift;
    logic [ADDR_W:0]   dl_q;

`ifdef NTT_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            drain_cnt <= '0;
            log_m     <= '0;
        end else if (!hold) begin
            case (state)
                IDLE: if (bus.start) begin
                    state  <= ISSUE;
                    rd_cnt <= '0;
                    log_m  <= '0;
                end
                ISSUE: if (rd_cnt == ADDR_W'(DEPTH - 1)) begin
                    state     <= DRAIN;
                    rd_cnt    <= '0;
                    drain_cnt <= '0;
                end else begin
                    rd_cnt <= rd_cnt + ADDR_W'(1);
                end
                // Last write of the stage lands in the final DRAIN cycle, so the
                // next stage can start reading immediately after.
                DRAIN: if (drain_cnt == CNT_W'(PIPE_LAT - 1)) begin
                    if (log_m == LOG_W'(NUM_STAGES - 1)) begin
                        state <= FINISH;
                    end else begin
                        log_m <= log_m + LOG_W'(1);
                        state <= ISSUE;
                    end
                end else begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                end
                FINISH: begin
                    state <= IDLE;
                    log_m <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_valid = (state == ISSUE) && !hold;
    assign cur_mode = mode_of(log_m, MODE1_START, MODE2_START);
    assign i_shift  = {1'b0, rd_cnt} >> (LOG_W'(MODE2_START) - log_m);

    assign bus.busy               = (state != IDLE);
    assign bus.done               = (state == FINISH);
    assign bus.log_m              = log_m;
    assign bus.mode               = cur_mode;
    assign bus.i                  = (cur_mode == MODE_1) ? i_shift : '0;
    assign bus.upper_read_address = (state == ISSUE) ? rd_cnt : '0;
    assign bus.lower_read_address = (state == ISSUE) ? rd_cnt : '0;

    ntt_addr_delay_line #(
        .PIPE_LAT (PIPE_LAT),
        .W        (ADDR_W + 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!hold),
        .d     ({rd_valid, rd_cnt}),
        .q     (dl_q)
    );

    assign bus.write_enable        = dl_q[ADDR_W] && !hold;
    assign bus.upper_write_address = dl_q[ADDR_W-1:0];
    assign bus.lower_write_address = dl_q[ADDR_W-1:0];
    assign bus.upper_data_input    = {bus.r2, bus.r1};
    assign bus.lower_data_input    = {bus.r4, bus.r3};
endmodule

// File: tb/tb_ntt_stage_controller.sv
// Scoreboard bench for ntt_stage_controller: timing model of reads/writes, reset, start filtering.
module tb_ntt_stage_controller;
    import ntt_ctrl_pkg::*;

    localparam int ADDR_W = 9;
    localparam int NS     = 12;
    localparam int PL     = 8;
    localparam int DEPTH  = 512;
    localparam int SLEN   = DEPTH + PL;
    localparam int TOTAL  = NS * SLEN;

    typedef struct {int due; int addr;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef NTT_CTRL_STALL_EN
    logic stall = 1'b0;
`endif
    always #5 clk = ~clk;

    ntt_stage_controller_if #(.ADDR_W(ADDR_W)) bus();

    ntt_stage_controller #(
        .ADDR_W(ADDR_W), .NUM_STAGES(NS), .PIPE_LAT(PL), .MODE1_START(5), .MODE2_START(9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef NTT_CTRL_STALL_EN
        .stall (stall),
`endif
        .bus   (bus)
    );

    exp_t q[$];
    int checks = 0, errors = 0;
    int teff = 0, rcyc = 0;
    bit active = 0, adv = 0;
    int we_cnt, done_cnt, busy_cnt, done_at;
    bit start_req = 0, stall_req = 0;
    logic [DATA_W-1:0] d1, d2, d3, d4;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_mode(input int stage);
        return (stage < 5) ? 0 : (stage < 9) ? 1 : 2;
    endfunction

    function automatic int exp_i(input int stage, input int pos);
        return (exp_mode(stage) == 1) ? (pos >> (9 - stage)) : 0;
    endfunction

    task automatic observe();
        bit   was_active;
        int   stage, pos;
        exp_t e;
        was_active = active;
        if (was_active) rcyc++;
        if (bus.write_enable) we_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.done) begin done_cnt++; done_at = rcyc; end
        if (was_active) begin
            if (adv) teff++;
            adv = !stall_req;
            if (stall_req) begin
                chk("stall_we", bus.write_enable, 0);
            end else begin
                if (teff <= TOTAL) begin
                    stage = (teff - 1) / SLEN;
                    pos   = (teff - 1) % SLEN;
                    chk("busy", bus.busy, 1);
                    chk("done_early", bus.done, 0);
                    chk("log_m", bus.log_m, stage);
                    if (pos < DEPTH) begin
                        chk("rd_addr", {bus.upper_read_address, bus.lower_read_address},
                            {pos[8:0], pos[8:0]});
                        q.push_back('{teff + PL, pos});
                    end else begin
                        chk("rd_addr_drain", {bus.upper_read_address, bus.lower_read_address}, 0);
                    end
                    if (pos == 100) begin
                        chk("mode", bus.mode, exp_mode(stage));
                        chk("i", bus.i, exp_i(stage, pos));
                    end
                end else begin
                    chk("done", bus.done, 1);
                    chk("busy_finish", bus.busy, 1);
                    active = 0;
                end
                if (bus.write_enable) begin
                    chk("upper_data", bus.upper_data_input, {d2, d1});
                    chk("lower_data", bus.lower_data_input, {d4, d3});
                    if (q.size() == 0) begin
                        chk("wr_unexpected", bus.write_enable, 0);
                    end else begin
                        e = q.pop_front();
                        chk("wr_time", teff, e.due);
                        chk("wr_addr_upper", bus.upper_write_address, e.addr);
                        chk("wr_addr_lower", bus.lower_write_address, e.addr);
                    end
                end else if (q.size() > 0 && q[0].due == teff) begin
                    chk("wr_missing", bus.write_enable, 1);
                    void'(q.pop_front());
                end
            end
        end else begin
            chk("idle_busy", bus.busy, 0);
            chk("idle_we", bus.write_enable, 0);
            chk("idle_done", bus.done, 0);
        end
        if (start_req && !was_active) begin
            active = 1; teff = 0; adv = 1; rcyc = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        d1 = DATA_W'($urandom); d2 = DATA_W'($urandom);
        d3 = DATA_W'($urandom); d4 = DATA_W'($urandom);
        bus.r1 = d1; bus.r2 = d2; bus.r3 = d3; bus.r4 = d4;
        bus.start = start_req;
`ifdef NTT_CTRL_STALL_EN
        stall = stall_req;
`endif
        #3;
        observe();
    endtask

    task automatic run_full(input bit with_stall);
        bit stalled_once;
        int extra;
        stalled_once = 0;
        extra = with_stall ? 5 : 0;
        we_cnt = 0; done_cnt = 0; busy_cnt = 0; done_at = -1;
        start_req = 1; tick(); start_req = 0;
        while (active && rcyc < 7000) begin
            // Extra starts in stage 6 and in the FINISH cycle must be ignored.
            start_req = (teff == 6 * SLEN + 49) || (teff == TOTAL);
            if (with_stall && teff == 200 && !stalled_once) begin
                stall_req = 1; repeat (5) tick(); stall_req = 0;
                stalled_once = 1;
            end else begin
                tick();
            end
        end
        start_req = 0;
        repeat (20) tick();
        chk("done_cycle", done_at, TOTAL + 1 + extra);
        chk("done_count", done_cnt, 1);
        chk("we_count", we_cnt, NS * DEPTH);
        chk("busy_cycles", busy_cnt, TOTAL + 1 + extra);
        chk("sb_empty", q.size(), 0);
    endtask

    initial begin
        bus.start = 0; bus.r1 = '0; bus.r2 = '0; bus.r3 = '0; bus.r4 = '0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_we", bus.write_enable, 0);
        chk("rst_log_m", bus.log_m, 0);
        chk("rst_rd", bus.upper_read_address, 0);
        chk("rst_wr", bus.upper_write_address, 0);
        @(negedge clk) rst_n = 1;
        repeat (3) tick();

        // Async reset in stage 3 at rd_cnt 100.
        start_req = 1; tick(); start_req = 0;
        while (active && teff < 3 * SLEN + 101) tick();
        #1 rst_n = 0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_we", bus.write_enable, 0);
        chk("mid_rst_log_m", bus.log_m, 0);
        chk("mid_rst_mode", bus.mode, 0);
        chk("mid_rst_i", bus.i, 0);
        chk("mid_rst_rd", {bus.upper_read_address, bus.lower_read_address}, 0);
        chk("mid_rst_wr", {bus.upper_write_address, bus.lower_write_address}, 0);
        active = 0;
        q.delete();
        @(negedge clk) rst_n = 1;
        repeat (20) tick();

        run_full(0);
`ifdef NTT_CTRL_STALL_EN
        run_full(1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
